// File: rtl/regfile_arb_pkg.sv
// Shared definitions for regfile_port_arbiter: the arbiter FSM state
// encoding and the address of the hardwired-zero register.
`timescale 1ns/1ps

package regfile_arb_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_STALL  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RESP   = 3'd4
    } arb_state_e;

    // Register 0 reads as zero and silently drops writes.
    localparam int unsigned X0_ADDR = 32'd0;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Bundle of the core, debug and register-file signals around the
// regfile_port_arbiter. The arbiter uses the slave modport; the
// surrounding core/UART/register-file environment uses master.
`timescale 1ns/1ps

interface regfile_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    // core writeback / decode side
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_a3;
    logic [ADDR_WIDTH-1:0] core_a1;
    logic [DATA_WIDTH-1:0] core_wd3;
    logic                  core_stall;
    // UART debug / loader side
    logic                  dbg_req;
    logic                  dbg_wr;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_ack;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    // register file ports
    logic                  rf_we3;
    logic [ADDR_WIDTH-1:0] rf_a3;
    logic [DATA_WIDTH-1:0] rf_wd3;
    logic [ADDR_WIDTH-1:0] rf_a1;
    logic [DATA_WIDTH-1:0] rf_rd1;
    // status
    logic                  init_done;

    modport slave (
        input  core_we, core_a3, core_a1, core_wd3,
        input  dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        input  rf_rd1,
        output core_stall, dbg_ack, dbg_rdata,
        output rf_we3, rf_a3, rf_wd3, rf_a1,
        output init_done
    );

    modport master (
        output core_we, core_a3, core_a1, core_wd3,
        output dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        output rf_rd1,
        input  core_stall, dbg_ack, dbg_rdata,
        input  rf_we3, rf_a3, rf_wd3, rf_a1,
        input  init_done
    );

endinterface

// File: rtl/regfile_arb_guard_ctr.sv
// Loadable down-counter with a zero flag. Used by the arbiter to hold off
// the debug side for a number of core-owned IDLE cycles after each access.
`timescale 1ns/1ps

module regfile_arb_guard_ctr #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load wins over decrement; decrement stops at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {WIDTH{1'b0}})) begin
            cnt_d = cnt_q - WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file write port and read port 1 between the core
// and the UART debug/loader path. The debug side is granted after a
// one-cycle STALL, performs its access in ACCESS and is acknowledged in
// RESP; a guard counter then keeps it away for GUARD_CYCLES IDLE cycles.
// Optional feature macro: REGFILE_ARB_INIT_EN -- when defined, every reset
// is followed by a sweep that writes zero to all registers.
`timescale 1ns/1ps

module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    regfile_port_arbiter_if.slave bus
);

    localparam int GUARD_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] X0_A = ADDR_WIDTH'(X0_ADDR);

`ifdef REGFILE_ARB_INIT_EN
    localparam arb_state_e RESET_STATE = ST_INIT;
    localparam logic       RESET_STALL = 1'b1;
`else
    localparam arb_state_e RESET_STATE = ST_IDLE;
    localparam logic       RESET_STALL = 1'b0;
`endif

    arb_state_e            state_q;
    arb_state_e            state_d;
    logic                  ack_q;
    logic                  ack_d;
    logic                  stall_q;
    logic                  stall_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    logic                  rf_we3_s;
    logic [ADDR_WIDTH-1:0] rf_a3_s;
    logic [ADDR_WIDTH-1:0] rf_a1_s;
    logic [DATA_WIDTH-1:0] rf_wd3_s;

    logic                  guard_load_s;
    logic                  guard_dec_s;
    logic                  guard_zero_s;

`ifdef REGFILE_ARB_INIT_EN
    logic [ADDR_WIDTH-1:0] init_ptr_q;
    logic [ADDR_WIDTH-1:0] init_ptr_d;
    logic                  init_done_q;
    logic                  init_done_d;
`endif

    regfile_arb_guard_ctr #(
        .WIDTH (GUARD_W)
    ) u_guard (
        .clk_i      (clk_i),
        .rst_ni     (reset_ni),
        .load_i     (guard_load_s),
        .load_val_i (GUARD_W'(GUARD_CYCLES)),
        .dec_i      (guard_dec_s),
        .zero_o     (guard_zero_s)
    );

    // Next state, register-file port steering and debug read capture
    always_comb begin
        state_d      = state_q;
        rf_we3_s     = 1'b0;
        rf_a3_s      = bus.core_a3;
        rf_wd3_s     = bus.core_wd3;
        rf_a1_s      = bus.core_a1;
        rdata_d      = rdata_q;
        guard_load_s = 1'b0;
        guard_dec_s  = 1'b0;
`ifdef REGFILE_ARB_INIT_EN
        init_ptr_d   = init_ptr_q;
        init_done_d  = init_done_q;
`endif
        case (state_q)
`ifdef REGFILE_ARB_INIT_EN
            ST_INIT: begin
                rf_we3_s = 1'b1;
                rf_a3_s  = init_ptr_q;
                rf_wd3_s = {DATA_WIDTH{1'b0}};
                if (init_ptr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    init_ptr_d  = init_ptr_q + ADDR_WIDTH'(1);
                end
            end
`endif
            ST_IDLE: begin
                // The core keeps the ports in the grant cycle, so its
                // writeback in that cycle still lands.
                rf_we3_s = bus.core_we && (bus.core_a3 != X0_A);
                if (!guard_zero_s) begin
                    guard_dec_s = 1'b1;
                end else if (bus.dbg_req) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STALL: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                rf_a1_s = bus.dbg_addr;
                if (bus.dbg_wr) begin
                    rf_we3_s = (bus.dbg_addr != X0_A);
                    rf_a3_s  = bus.dbg_addr;
                    rf_wd3_s = bus.dbg_wdata;
                end else begin
                    rdata_d  = (bus.dbg_addr == X0_A) ? {DATA_WIDTH{1'b0}} : bus.rf_rd1;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // Core is running again in this cycle; let its writeback through.
                rf_we3_s     = bus.core_we && (bus.core_a3 != X0_A);
                guard_load_s = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        stall_d = (state_d == ST_INIT) || (state_d == ST_STALL) || (state_d == ST_ACCESS);
        ack_d   = (state_d == ST_RESP);
    end

    // FSM state and registered handshake outputs
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= RESET_STATE;
            ack_q   <= 1'b0;
            stall_q <= RESET_STALL;
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            stall_q <= stall_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef REGFILE_ARB_INIT_EN
    // Clearing-sweep pointer and sticky completion flag
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            init_ptr_q  <= {ADDR_WIDTH{1'b0}};
            init_done_q <= 1'b0;
        end else begin
            init_ptr_q  <= init_ptr_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus.init_done = init_done_q;
`else
    assign bus.init_done = 1'b1;
`endif

    assign bus.core_stall = stall_q;
    assign bus.dbg_ack    = ack_q;
    assign bus.dbg_rdata  = rdata_q;
    assign bus.rf_we3     = rf_we3_s;
    assign bus.rf_a3      = rf_a3_s;
    assign bus.rf_wd3     = rf_wd3_s;
    assign bus.rf_a1      = rf_a1_s;

endmodule
